// File: rtl/rgb_pkg.sv
// Shared types for the multi-LED RGB PWM driver.
// Mode encoding and cfg_led width helper.
package rgb_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STATIC  = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  function automatic int led_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rgb_tick_gen.sv
// Shared timebase: prescaler, PWM counter, frame pulse
// and the global blink phase used by every LED.
module rgb_tick_gen #(
  parameter int TICK_CYCLES  = 500,
  parameter int DUTY_W       = 8,
  parameter int BLINK_FRAMES = 64
) (
  input  logic              clk,
  input  logic              nrst,
  output logic [DUTY_W-1:0] pwm_cnt,
  output logic              frame,
  output logic              frame_o,
  output logic              phase
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_CYCLES - 1);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0] pre;
  logic [BW-1:0] bcnt;
  logic          tick;

  assign tick  = (pre == PMAX);
  assign frame = tick && (pwm_cnt == '1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pre     <= '0;
      pwm_cnt <= '0;
      frame_o <= 1'b0;
    end else begin
      pre     <= tick ? '0 : pre + 1'b1;
      frame_o <= frame;
      if (tick)
        pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Phase starts "on" and flips every BLINK_FRAMES frames.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (frame) begin
      if (bcnt == BMAX) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgb_pwm_multi.sv
// Multi-LED RGB PWM driver with shadowed config committed
// at frame boundaries; OFF/STATIC/BLINK/BREATHE per LED.
module rgb_pwm_multi
  import rgb_pkg::*;
#(
  parameter int TICK_CYCLES  = 500,
  parameter int DUTY_W       = 8,
  parameter int NUM_LEDS     = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        cfg_we,
  input  logic [led_w(NUM_LEDS)-1:0]  cfg_led,
  input  logic [1:0]                  cfg_mode,
  input  logic [3*DUTY_W-1:0]         cfg_rgb,
  output logic [NUM_LEDS-1:0]         led_r,
  output logic [NUM_LEDS-1:0]         led_g,
  output logic [NUM_LEDS-1:0]         led_b,
  output logic                        frame_o
);

  localparam int LW = led_w(NUM_LEDS);
  localparam logic [DUTY_W-1:0] DMAX = '1;
  localparam logic [DUTY_W-1:0] DONE = DUTY_W'(1);

  logic [DUTY_W-1:0] pwm_cnt;
  logic              frame;
  logic              phase;

  rgb_tick_gen #(
    .TICK_CYCLES (TICK_CYCLES),
    .DUTY_W      (DUTY_W),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_tick (
    .clk    (clk),
    .nrst   (nrst),
    .pwm_cnt(pwm_cnt),
    .frame  (frame),
    .frame_o(frame_o),
    .phase  (phase)
  );

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
    mode_t               sh_mode;
    mode_t               act_mode;
    logic [3*DUTY_W-1:0] sh_rgb;
    logic [3*DUTY_W-1:0] act_rgb;
    logic [DUTY_W-1:0]   env;
    logic                dir_dn;
    logic                sel;

    // Out-of-range indices never match any LED.
    assign sel = cfg_we && (cfg_led == LW'(i));

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        sh_mode <= MODE_OFF;
        sh_rgb  <= '0;
      end else if (sel) begin
        sh_mode <= mode_t'(cfg_mode);
        sh_rgb  <= cfg_rgb;
      end
    end

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        act_mode <= MODE_OFF;
        act_rgb  <= '0;
        env      <= '0;
        dir_dn   <= 1'b0;
      end else if (frame) begin
        act_mode <= sh_mode;
        act_rgb  <= sh_rgb;
        if (sh_mode != act_mode) begin
          env    <= '0;
          dir_dn <= 1'b0;
        end else if (act_mode == MODE_BREATHE) begin
          if (!dir_dn) begin
            if (env == DMAX) begin
              dir_dn <= 1'b1;
              env    <= DMAX - 1'b1;
            end else begin
              env <= env + 1'b1;
            end
          end else begin
            if (env == '0) begin
              dir_dn <= 1'b0;
              env    <= DONE;
            end else begin
              env <= env - 1'b1;
            end
          end
        end
      end
    end

    for (genvar c = 0; c < 3; c++) begin : g_ch
      logic [DUTY_W-1:0] duty;
      logic [DUTY_W-1:0] br;
      logic [DUTY_W-1:0] deff;
      logic              pin;

      assign duty = act_rgb[(2-c)*DUTY_W +: DUTY_W];
      assign br   = DUTY_W'(({{DUTY_W{1'b0}}, duty}
                    * {{DUTY_W{1'b0}}, env}) >> DUTY_W);

      always_comb begin
        deff = '0;
        case (act_mode)
          MODE_STATIC:  deff = duty;
          MODE_BLINK:   deff = phase ? duty : '0;
          MODE_BREATHE: deff = br;
          default:      deff = '0;
        endcase
      end

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
          pin <= 1'b0;
        else
          pin <= (pwm_cnt < deff);
      end
    end

    assign led_r[i] = g_ch[0].pin;
    assign led_g[i] = g_ch[1].pin;
    assign led_b[i] = g_ch[2].pin;
  end

endmodule

// File: tb/tb_rgb_pwm_multi.sv
// Scoreboard bench for rgb_pwm_multi: per-frame high counts
// from a frame-level model, checked by a frame_o-driven monitor.
module tb_rgb_pwm_multi;

  localparam int TC = 4;
  localparam int DW = 4;
  localparam int NL = 2;
  localparam int BF = 2;
  localparam int FR = 64;

  typedef logic [6*7-1:0] exp_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        cfg_we = 1'b0;
  logic [0:0]  cfg_led = '0;
  logic [1:0]  cfg_led3 = 2'd3;
  logic [1:0]  cfg_mode = '0;
  logic [11:0] cfg_rgb = '0;
  logic [1:0]  led_r, led_g, led_b;
  logic        frame_o;
  logic [2:0]  r3, g3, b3;
  logic        frame3;

  always #5 clk = ~clk;

  rgb_pwm_multi #(
    .TICK_CYCLES(TC), .DUTY_W(DW),
    .NUM_LEDS(NL), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .nrst(nrst), .cfg_we(cfg_we),
    .cfg_led(cfg_led), .cfg_mode(cfg_mode),
    .cfg_rgb(cfg_rgb), .led_r(led_r),
    .led_g(led_g), .led_b(led_b), .frame_o(frame_o)
  );

  // Second instance only ever sees LED index 3, which it lacks.
  rgb_pwm_multi #(
    .TICK_CYCLES(TC), .DUTY_W(DW),
    .NUM_LEDS(3), .BLINK_FRAMES(BF)
  ) dut3 (
    .clk(clk), .nrst(nrst), .cfg_we(cfg_we),
    .cfg_led(cfg_led3), .cfg_mode(cfg_mode),
    .cfg_rgb(cfg_rgb), .led_r(r3),
    .led_g(g3), .led_b(b3), .frame_o(frame3)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference model, frame granularity
  exp_t        q[$];
  int          e;
  int          k;
  logic [1:0]  shm[NL];
  logic [1:0]  actm[NL];
  logic [11:0] shd[NL];
  logic [11:0] actd[NL];
  int          st[NL];

  function automatic int tri_env(input int t);
    int m;
    m = t % 30;
    return (m <= 15) ? m : 30 - m;
  endfunction

  function automatic int eff(input int mode, input int duty,
                             input int env, input bit ph);
    case (mode)
      1: return duty;
      2: return ph ? duty : 0;
      3: return (duty * env) / 16;
      default: return 0;
    endcase
  endfunction

  task automatic push_exp();
    exp_t x;
    bit   ph;
    int   duty;
    x  = '0;
    ph = ((k / BF) % 2) == 0;
    for (int i = 0; i < NL; i++)
      for (int c = 0; c < 3; c++) begin
        duty = int'((actd[i] >> (4 * (2 - c))) & 12'hF);
        x[(i*3+c)*7 +: 7] =
          7'(4 * eff(int'(actm[i]), duty, tri_env(k - st[i]), ph));
      end
    q.push_back(x);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      shm[i] = 2'd0; actm[i] = 2'd0;
      shd[i] = '0;   actd[i] = '0;
      st[i]  = 0;
    end
    e = 0;
    k = 0;
    q.delete();
    push_exp();
  endtask

  task automatic cyc(input bit we, input int led,
                     input int mode, input int rgb);
    cfg_we   = we;
    cfg_led  = 1'(led);
    cfg_mode = 2'(mode);
    cfg_rgb  = 12'(rgb);
    @(posedge clk);
    e++;
    if (e % FR == 0) begin
      k = e / FR;
      for (int i = 0; i < NL; i++) begin
        if (shm[i] != actm[i]) st[i] = k;
        actm[i] = shm[i];
        actd[i] = shd[i];
      end
      push_exp();
    end
    if (we) begin
      shm[led] = 2'(mode);
      shd[led] = 12'(rgb);
    end
    #1 cfg_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0);
  endtask

  task automatic go_off(input int off);
    while (e % FR != off) cyc(0, 0, 0, 0);
  endtask

  task automatic wr(input int led, input int mode, input int rgb);
    cyc(1, led, mode, rgb);
  endtask

  task automatic do_reset(input int hold);
    nrst = 1'b0;
    model_reset();
    repeat (hold) @(posedge clk);
    @(negedge clk);
    #1 nrst = 1'b1;
  endtask

  // Monitor: one window of samples per frame, closed by frame_o
  int hi[6];
  int ns;
  int f3;
  int bad3;
  bit rst_seen = 1'b0;

  task automatic clear_win();
    for (int j = 0; j < 6; j++) hi[j] = 0;
    ns = 0; f3 = 0; bad3 = 0;
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (!nrst) begin
      if (!rst_seen)
        chk("reset_pins", int'({led_r, led_g, led_b}), 0);
      rst_seen = 1'b1;
      clear_win();
    end else begin
      rst_seen = 1'b0;
      for (int i = 0; i < NL; i++) begin
        hi[i*3+0] += int'(led_r[i]);
        hi[i*3+1] += int'(led_g[i]);
        hi[i*3+2] += int'(led_b[i]);
      end
      ns++;
      bad3 += int'(|{r3, g3, b3});
      f3   += int'(frame3);
      if (frame_o) begin
        chk("frame_period", ns, FR);
        chk("bad_index_pins", bad3, 0);
        chk("bad_index_frame", f3, 1);
        if (q.size() == 0) begin
          chk("scoreboard_empty", 0, 1);
        end else begin
          x = q.pop_front();
          for (int j = 0; j < 6; j++)
            chk($sformatf("high_led%0d_ch%0d", j / 3, j % 3),
                hi[j], int'(x[j*7 +: 7]));
        end
        clear_win();
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clear_win();
    do_reset(3);
    idle(200);
    // STATIC duty
    go_off(10);
    wr(0, 1, 12'h80F);
    idle(3 * FR);
    // write coinciding with the frame condition
    go_off(63);
    wr(1, 1, 12'h400);
    idle(3 * FR);
    go_off(20);
    wr(1, 1, 12'h400);
    go_off(40);
    wr(1, 1, 12'h200);
    idle(2 * FR);
    // BLINK
    go_off(5);
    wr(0, 2, 12'hF00);
    idle(6 * FR);
    // BREATHE, full triangle then restart
    go_off(5);
    wr(0, 3, 12'hF00);
    idle(33 * FR);
    go_off(5);
    wr(0, 1, 12'hF00);
    idle(2 * FR);
    go_off(5);
    wr(0, 3, 12'hF00);
    idle(5 * FR);
    // randomized traffic
    repeat (30) begin
      n = int'($urandom_range(0, 2));
      repeat (n) begin
        go_off(int'($urandom_range(0, FR - 1)));
        wr(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 12'hFFF)));
      end
      idle(int'($urandom_range(1, FR)));
    end
    // reset mid-frame with a lit LED
    go_off(5);
    wr(0, 1, 12'hF00);
    idle(FR);
    go_off(30);
    do_reset(1);
    idle(3 * FR);
    repeat (5) begin
      go_off(int'($urandom_range(0, FR - 1)));
      wr(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
         int'($urandom_range(0, 12'hFFF)));
      idle(FR);
    end
    go_off(10);
    chk("pending_frames", q.size(), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
